// File: rtl/nib_pack.sv
// nib_pack: packs serial nibbles (MS nibble first) into 16-bit words,
// with a separate output register so one word can wait while the next fills.
module nib_pack (
  input  logic        CLK,
  input  logic        RESET_L,
  input  logic [3:0]  NIB_IN,
  input  logic        NIB_VALID,
  output logic        NIB_READY,
  input  logic        FLUSH,
  output logic [15:0] NIBBLES,
  output logic        WORD_VALID,
  input  logic        WORD_READY,
  output logic [1:0]  NIB_CNT,
  output logic [7:0]  WORD_CNT
);
  typedef enum logic {FILL, HOLD} state_t;
  state_t      r_state;
  logic [15:0] r_asm;
  logic [1:0]  r_cnt;
  logic [15:0] r_word;
  logic [7:0]  r_wcnt;
  logic        w_slot_free;
  logic        w_acc;
  logic        w_full;
  logic        w_flush;
  logic        w_load;
  logic [15:0] w_asm_next;
  assign w_slot_free = (r_state == FILL) | WORD_READY;
  assign NIB_READY   = (r_cnt != 2'd3) | w_slot_free;
  assign w_acc       = NIB_VALID & NIB_READY;
  // unfilled slots stay zero because the assembly register clears on every load
  assign w_asm_next  = w_acc ? (r_asm | ({12'h000, NIB_IN} << (4'd12 - {r_cnt, 2'b00}))) : r_asm;
  assign w_full      = w_acc & (r_cnt == 2'd3);
  assign w_flush     = FLUSH & w_slot_free & (w_acc | (r_cnt != 2'd0));
  assign w_load      = w_full | w_flush;
  assign NIBBLES     = r_word;
  assign WORD_VALID  = (r_state == HOLD);
  assign NIB_CNT     = r_cnt;
  assign WORD_CNT    = r_wcnt;
  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      r_state <= FILL;
      r_asm   <= 16'h0000;
      r_cnt   <= 2'd0;
      r_word  <= 16'h0000;
      r_wcnt  <= 8'd0;
    end else begin
      r_asm   <= w_load ? 16'h0000 : w_asm_next;
      r_cnt   <= w_load ? 2'd0 : r_cnt + {1'b0, w_acc};
      r_word  <= w_load ? w_asm_next : r_word;
      r_wcnt  <= w_load ? r_wcnt + 8'd1 : r_wcnt;
      r_state <= w_load ? HOLD : (WORD_READY ? FILL : r_state);
    end
  end
endmodule
